// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART echo design: FSM encoding and frame constants.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam int   DATA_BITS  = 8;
    localparam int   IDX_W      = $clog2(DATA_BITS);
    localparam int   CNT_W      = 16;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: two-flop synchronizer, mid-bit sampling, sticky framing-error flag.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_serial,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 frame_err
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic                 meta_reg, sync_reg;
    uart_state_t          state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [IDX_W-1:0]     bit_idx_reg, bit_idx_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [DATA_BITS-1:0] data_reg, data_next;
    logic                 valid_reg, valid_next;
    logic                 err_reg, err_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_reg    <= IDLE_LEVEL;
            sync_reg    <= IDLE_LEVEL;
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            meta_reg    <= rx_serial;
            sync_reg    <= meta_reg;
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            data_reg    <= data_next;
            valid_reg   <= valid_next;
            err_reg     <= err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        data_next    = data_reg;
        valid_next   = 1'b0;
        err_next     = err_reg;
        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (!sync_reg) state_next = ST_START;
            end
            // A start bit that is high again at mid-bit is treated as a glitch.
            ST_START: begin
                if (cnt_reg == HALF_CNT) begin
                    cnt_next   = '0;
                    state_next = sync_reg ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_reg == LAST_CNT) begin
                    cnt_next     = '0;
                    shift_next   = {sync_reg, shift_reg[DATA_BITS-1:1]};
                    bit_idx_next = bit_idx_reg + 1'b1;
                    if (bit_idx_reg == IDX_W'(DATA_BITS - 1)) state_next = ST_STOP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_reg == LAST_CNT) begin
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                    if (sync_reg) begin
                        data_next  = shift_reg;
                        valid_next = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign rx_valid  = valid_reg;
    assign rx_data   = data_reg;
    assign frame_err = err_reg;

endmodule

// File: rtl/uart_tx.sv
// 8N1 transmitter with a registered serial output; tx_done marks the end of the stop bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_byte,
    output logic                 o_tx_serial,
    output logic                 tx_active,
    output logic                 tx_done
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    uart_state_t          state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [IDX_W-1:0]     bit_idx_reg, bit_idx_next;
    logic [DATA_BITS-1:0] data_reg, data_next;
    logic                 serial_reg, serial_next;
    logic                 done_reg, done_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            data_reg    <= '0;
            serial_reg  <= IDLE_LEVEL;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_idx_reg <= bit_idx_next;
            data_reg    <= data_next;
            serial_reg  <= serial_next;
            done_reg    <= done_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        bit_idx_next = bit_idx_reg;
        data_next    = data_reg;
        serial_next  = serial_reg;
        done_next    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                serial_next  = IDLE_LEVEL;
                cnt_next     = '0;
                bit_idx_next = '0;
                if (tx_start) begin
                    data_next   = tx_byte;
                    serial_next = 1'b0;
                    state_next  = ST_START;
                end
            end
            ST_START: begin
                if (cnt_reg == LAST_CNT) begin
                    cnt_next    = '0;
                    serial_next = data_reg[0];
                    state_next  = ST_DATA;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_reg == LAST_CNT) begin
                    cnt_next = '0;
                    if (bit_idx_reg == IDX_W'(DATA_BITS - 1)) begin
                        bit_idx_next = '0;
                        serial_next  = IDLE_LEVEL;
                        state_next   = ST_STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                        serial_next  = data_reg[bit_idx_reg + 1'b1];
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_reg == LAST_CNT) begin
                    cnt_next   = '0;
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign o_tx_serial = serial_reg;
    assign tx_active   = (state_reg != ST_IDLE);
    assign tx_done     = done_reg;

endmodule

// File: rtl/uart_echo_top.sv
// UART loopback: received bytes are echoed through a one-deep drop-oldest buffer; LEDs show status.
module uart_echo_top
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] key,
    output logic [9:0] ledr,
    input  logic       i_rx_serial,
    output logic       o_tx_serial
);

    logic                 rx_valid;
    logic [DATA_BITS-1:0] rx_data;
    logic                 frame_err;
    logic                 tx_active;
    logic                 tx_done;

    logic                 tx_start_reg, tx_start_next;
    logic [DATA_BITS-1:0] tx_byte_reg, tx_byte_next;
    logic                 pend_valid_reg, pend_valid_next;
    logic [DATA_BITS-1:0] pend_byte_reg, pend_byte_next;
    logic [DATA_BITS-1:0] led_byte_reg, led_byte_next;
    logic                 key_reg;
    logic                 launch;
    logic                 unused_key;

    assign unused_key = key[0];

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk       (clk),
        .reset     (reset),
        .rx_serial (i_rx_serial),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .frame_err (frame_err)
    );

    uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk         (clk),
        .reset       (reset),
        .tx_start    (tx_start_reg),
        .tx_byte     (tx_byte_reg),
        .o_tx_serial (o_tx_serial),
        .tx_active   (tx_active),
        .tx_done     (tx_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_start_reg   <= 1'b0;
            tx_byte_reg    <= '0;
            pend_valid_reg <= 1'b0;
            pend_byte_reg  <= '0;
            led_byte_reg   <= '0;
            key_reg        <= 1'b0;
        end else begin
            tx_start_reg   <= tx_start_next;
            tx_byte_reg    <= tx_byte_next;
            pend_valid_reg <= pend_valid_next;
            pend_byte_reg  <= pend_byte_next;
            led_byte_reg   <= led_byte_next;
            key_reg        <= key[1];
        end
    end

    // A fresh byte launches only into a truly idle transmitter; otherwise the
    // end of a frame drains whatever is newest, a same-cycle rx_valid winning.
    assign launch = (rx_valid | pend_valid_reg) &
                    (tx_done | (~tx_active & ~tx_start_reg & ~pend_valid_reg));

    always_comb begin
        tx_start_next   = 1'b0;
        tx_byte_next    = tx_byte_reg;
        pend_valid_next = pend_valid_reg;
        pend_byte_next  = pend_byte_reg;
        led_byte_next   = led_byte_reg;
        if (rx_valid) led_byte_next = rx_data;
        if (launch) begin
            tx_start_next   = 1'b1;
            tx_byte_next    = rx_valid ? rx_data : pend_byte_reg;
            pend_valid_next = 1'b0;
        end else if (rx_valid) begin
            pend_valid_next = 1'b1;
            pend_byte_next  = rx_data;
        end
    end

    assign ledr = {frame_err, key_reg, led_byte_reg};

endmodule

// File: tb/tb_uart_echo_top.sv
// Directed bench for uart_echo_top: serial stimulus, a line decoder model and per-feature checks.
module tb_uart_echo_top;

    localparam int CPB      = 8;
    localparam int CPB_SLOW = 434;

    logic       clk_tb   = 1'b0;
    logic       reset    = 1'b1;
    logic [1:0] key      = 2'b00;
    logic       rx_line  = 1'b1;
    logic       rx_line2 = 1'b1;
    logic [9:0] ledr, ledr2;
    logic       tx_line, tx_line2;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    always #5 clk_tb = ~clk_tb;
    always @(posedge clk_tb) cycle <= cycle + 1;

    uart_echo_top #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk_tb),
        .reset       (reset),
        .key         (key),
        .ledr        (ledr),
        .i_rx_serial (rx_line),
        .o_tx_serial (tx_line)
    );

    uart_echo_top dut2 (
        .clk         (clk_tb),
        .reset       (reset),
        .key         (key),
        .ledr        (ledr2),
        .i_rx_serial (rx_line2),
        .o_tx_serial (tx_line2)
    );

    // Event monitors for the fast instance
    int         rx_valid_cnt = 0;
    int         tx_done_cnt  = 0;
    int         rx_valid_time = 0;
    logic [7:0] rx_valid_data = 8'h00;
    int         done_q[$];

    always @(negedge clk_tb) begin
        if (dut.rx_valid === 1'b1) begin
            rx_valid_cnt  = rx_valid_cnt + 1;
            rx_valid_time = cycle;
            rx_valid_data = dut.rx_data;
        end
        if (dut.tx_done === 1'b1) begin
            tx_done_cnt = tx_done_cnt + 1;
            done_q.push_back(cycle);
        end
    end

    // Reference decoder of the transmit line, sampling mid-bit
    logic [7:0] tx_q[$];
    logic       tx_ok_q[$];
    int         tx_start_q[$];

    initial begin : tx_decoder
        logic [7:0] b;
        logic       ok;
        int         t0;
        forever begin
            @(negedge clk_tb);
            if (reset === 1'b0 && tx_line === 1'b0) begin
                t0 = cycle;
                repeat (CPB / 2) @(negedge clk_tb);
                ok = (tx_line === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk_tb);
                    b[i] = tx_line;
                end
                repeat (CPB) @(negedge clk_tb);
                ok = ok && (tx_line === 1'b1);
                tx_q.push_back(b);
                tx_ok_q.push_back(ok);
                tx_start_q.push_back(t0);
            end
        end
    end

    logic [7:0] force_byte = 8'h00;

    task automatic clear_queues();
        tx_q.delete();
        tx_ok_q.delete();
        tx_start_q.delete();
        done_q.delete();
    endtask

    task automatic drive_level(input int which, input logic v, input int cycles);
        if (which == 0) rx_line = v;
        else            rx_line2 = v;
        repeat (cycles) @(negedge clk_tb);
    endtask

    task automatic send_frame(input int which, input logic [7:0] b, input logic stop_bit, input int cpb);
        drive_level(which, 1'b0, cpb);
        for (int i = 0; i < 8; i++) drive_level(which, b[i], cpb);
        drive_level(which, stop_bit, cpb);
        drive_level(which, 1'b1, 0);
    endtask

    task automatic pulse_rx_valid(input logic [7:0] b, input int n);
        force_byte = b;
        force dut.rx_data  = force_byte;
        force dut.rx_valid = 1'b1;
        repeat (n) @(negedge clk_tb);
        release dut.rx_valid;
        release dut.rx_data;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n;
        n = 0;
        while (tx_done_cnt < target && n < budget) begin
            @(negedge clk_tb);
            n++;
        end
    endtask

    task automatic test_reset();
        int n, rv0, td0;
        reset = 1'b1;
        repeat (3) @(negedge clk_tb);
        checks++;
        if (tx_line !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx_line); end
        checks++;
        if (ledr !== 10'h000) begin errors++; $display("FAIL reset_ledr: got %h expected 000", ledr); end
        checks++;
        if (dut.rx_valid !== 1'b0 || dut.tx_done !== 1'b0) begin
            errors++; $display("FAIL reset_pulses: rx_valid %b tx_done %b expected 0 0", dut.rx_valid, dut.tx_done);
        end
        reset = 1'b0;
        @(negedge clk_tb);
        key = 2'b10;
        send_frame(0, 8'h81, 1'b1, CPB);
        n = 0;
        while (tx_line !== 1'b0 && n < 20) begin @(negedge clk_tb); n++; end
        checks++;
        if (tx_line !== 1'b0 || ledr !== 10'h181) begin
            errors++; $display("FAIL reset_setup: tx %b ledr %h expected 0 181", tx_line, ledr);
        end
        reset = 1'b1;
        @(negedge clk_tb);
        checks++;
        if (tx_line !== 1'b1) begin errors++; $display("FAIL reset_midframe_tx: got %b expected 1", tx_line); end
        checks++;
        if (ledr !== 10'h000) begin errors++; $display("FAIL reset_midframe_ledr: got %h expected 000", ledr); end
        @(negedge clk_tb);
        reset = 1'b0;
        key   = 2'b00;
        rv0 = rx_valid_cnt;
        td0 = tx_done_cnt;
        repeat (100) @(negedge clk_tb);
        checks++;
        if (rx_valid_cnt != rv0 || tx_done_cnt != td0 || tx_line !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle: rx_valid %0d tx_done %0d tx %b expected 0 0 1",
                     rx_valid_cnt - rv0, tx_done_cnt - td0, tx_line);
        end
        clear_queues();
    endtask

    task automatic test_echo_55();
        int rv0, td0;
        clear_queues();
        rv0 = rx_valid_cnt;
        td0 = tx_done_cnt;
        send_frame(0, 8'h55, 1'b1, CPB);
        wait_done(td0 + 1, 200);
        repeat (20) @(negedge clk_tb);
        checks++;
        if (rx_valid_cnt - rv0 != 1 || rx_valid_data !== 8'h55) begin
            errors++; $display("FAIL echo_rx: pulses %0d data %h expected 1 55", rx_valid_cnt - rv0, rx_valid_data);
        end
        checks++;
        if (ledr[7:0] !== 8'h55) begin errors++; $display("FAIL echo_led: got %h expected 55", ledr[7:0]); end
        checks++;
        if (tx_q.size() != 1 || tx_done_cnt - td0 != 1) begin
            errors++; $display("FAIL echo_count: frames %0d done %0d expected 1 1", tx_q.size(), tx_done_cnt - td0);
        end else begin
            checks++;
            if (tx_q[0] !== 8'h55 || tx_ok_q[0] !== 1'b1) begin
                errors++; $display("FAIL echo_byte: got %h framing %b expected 55 1", tx_q[0], tx_ok_q[0]);
            end
            checks++;
            if (tx_start_q[0] - rx_valid_time != 2) begin
                errors++; $display("FAIL echo_latency: got %0d expected 2", tx_start_q[0] - rx_valid_time);
            end
            checks++;
            if (done_q.size() != 1 || done_q[0] - tx_start_q[0] != 80) begin
                errors++; $display("FAIL echo_done_time: got %0d expected 80",
                                   (done_q.size() > 0) ? done_q[0] - tx_start_q[0] : -1);
            end
        end
    endtask

    task automatic test_pending();
        int td0;
        clear_queues();
        td0 = tx_done_cnt;
        pulse_rx_valid(8'h37, 2);
        wait_done(td0 + 2, 400);
        repeat (20) @(negedge clk_tb);
        checks++;
        if (tx_q.size() != 2 || tx_done_cnt - td0 != 2 || done_q.size() != 2) begin
            errors++; $display("FAIL pending_count: frames %0d done %0d expected 2 2", tx_q.size(), tx_done_cnt - td0);
        end else begin
            checks++;
            if (tx_q[0] !== 8'h37 || tx_q[1] !== 8'h37 || tx_ok_q[0] !== 1'b1 || tx_ok_q[1] !== 1'b1) begin
                errors++; $display("FAIL pending_bytes: got %h %h expected 37 37", tx_q[0], tx_q[1]);
            end
            checks++;
            if (tx_start_q[1] - done_q[0] != 2 || done_q[1] - tx_start_q[1] != 80) begin
                errors++; $display("FAIL pending_timing: restart %0d frame %0d expected 2 80",
                                   tx_start_q[1] - done_q[0], done_q[1] - tx_start_q[1]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int td0;
        clear_queues();
        td0 = tx_done_cnt;
        send_frame(0, 8'hA5, 1'b1, CPB);
        repeat (5) @(negedge clk_tb);
        pulse_rx_valid(8'h3C, 1);
        repeat (10) @(negedge clk_tb);
        pulse_rx_valid(8'hFF, 1);
        wait_done(td0 + 2, 400);
        repeat (100) @(negedge clk_tb);
        checks++;
        if (tx_q.size() != 2 || tx_done_cnt - td0 != 2) begin
            errors++; $display("FAIL b2b_count: frames %0d done %0d expected 2 2", tx_q.size(), tx_done_cnt - td0);
        end else begin
            checks++;
            if (tx_q[0] !== 8'hA5 || tx_q[1] !== 8'hFF) begin
                errors++; $display("FAIL b2b_bytes: got %h %h expected a5 ff", tx_q[0], tx_q[1]);
            end
        end
        checks++;
        if (ledr[7:0] !== 8'hFF) begin errors++; $display("FAIL b2b_led: got %h expected ff", ledr[7:0]); end
    endtask

    task automatic test_collision();
        int td0, n;
        clear_queues();
        td0 = tx_done_cnt;
        pulse_rx_valid(8'h21, 1);
        repeat (10) @(negedge clk_tb);
        pulse_rx_valid(8'h42, 1);
        n = 0;
        while (dut.tx_done !== 1'b1 && n < 200) begin @(negedge clk_tb); n++; end
        pulse_rx_valid(8'h84, 1);
        wait_done(td0 + 2, 400);
        repeat (100) @(negedge clk_tb);
        checks++;
        if (tx_q.size() != 2 || tx_done_cnt - td0 != 2) begin
            errors++; $display("FAIL collide_count: frames %0d done %0d expected 2 2", tx_q.size(), tx_done_cnt - td0);
        end else begin
            checks++;
            if (tx_q[0] !== 8'h21 || tx_q[1] !== 8'h84) begin
                errors++; $display("FAIL collide_bytes: got %h %h expected 21 84", tx_q[0], tx_q[1]);
            end
        end
    endtask

    task automatic test_frame_err();
        int rv0;
        logic [7:0] led_before;
        clear_queues();
        led_before = ledr[7:0];
        checks++;
        if (ledr[9] !== 1'b0) begin errors++; $display("FAIL ferr_before: got %b expected 0", ledr[9]); end
        rv0 = rx_valid_cnt;
        send_frame(0, 8'h12, 1'b0, CPB);
        repeat (20) @(negedge clk_tb);
        checks++;
        if (rx_valid_cnt != rv0) begin errors++; $display("FAIL ferr_valid: got %0d pulses expected 0", rx_valid_cnt - rv0); end
        checks++;
        if (ledr[9] !== 1'b1 || ledr[7:0] !== led_before) begin
            errors++; $display("FAIL ferr_led: got %h expected %h", ledr, {2'b10, led_before});
        end
        rx_line = 1'b0;
        @(negedge clk_tb);
        rx_line = 1'b1;
        repeat (50) @(negedge clk_tb);
        checks++;
        if (rx_valid_cnt != rv0 || tx_q.size() != 0 || tx_line !== 1'b1) begin
            errors++; $display("FAIL glitch: pulses %0d frames %0d tx %b expected 0 0 1",
                               rx_valid_cnt - rv0, tx_q.size(), tx_line);
        end
    endtask

    task automatic test_key();
        checks++;
        if (ledr[8] !== 1'b0) begin errors++; $display("FAIL key_idle: got %b expected 0", ledr[8]); end
        key = 2'b10;
        checks++;
        if (ledr[8] !== 1'b0) begin errors++; $display("FAIL key_nodelay: got %b expected 0", ledr[8]); end
        @(negedge clk_tb);
        key = 2'b00;
        checks++;
        if (ledr[8] !== 1'b1) begin errors++; $display("FAIL key_high: got %b expected 1", ledr[8]); end
        @(negedge clk_tb);
        checks++;
        if (ledr[8] !== 1'b0) begin errors++; $display("FAIL key_low: got %b expected 0", ledr[8]); end
    endtask

    task automatic test_baud_434();
        int n, t_fall, t_rise, t_fall2, t_rise2;
        drive_level(1, 1'b0, CPB_SLOW);
        for (int i = 0; i < 8; i++) drive_level(1, 8'hC3 >> i, CPB_SLOW);
        rx_line2 = 1'b1;
        n = 0;
        while (tx_line2 !== 1'b0 && n < CPB_SLOW + 20) begin @(negedge clk_tb); n++; end
        t_fall = cycle;
        while (tx_line2 !== 1'b1 && n < 3 * CPB_SLOW) begin @(negedge clk_tb); n++; end
        t_rise = cycle;
        while (tx_line2 !== 1'b0 && n < 6 * CPB_SLOW) begin @(negedge clk_tb); n++; end
        t_fall2 = cycle;
        while (tx_line2 !== 1'b1 && n < 12 * CPB_SLOW) begin @(negedge clk_tb); n++; end
        t_rise2 = cycle;
        checks++;
        if (ledr2[7:0] !== 8'hC3 || dut2.rx_data !== 8'hC3) begin
            errors++; $display("FAIL slow_rx: led %h data %h expected c3 c3", ledr2[7:0], dut2.rx_data);
        end
        checks++;
        if (t_rise - t_fall != CPB_SLOW) begin
            errors++; $display("FAIL slow_bit_period: got %0d expected %0d", t_rise - t_fall, CPB_SLOW);
        end
        checks++;
        if (t_rise2 - t_fall2 != 4 * CPB_SLOW) begin
            errors++; $display("FAIL slow_zero_run: got %0d expected %0d", t_rise2 - t_fall2, 4 * CPB_SLOW);
        end
    endtask

    initial begin
        @(negedge clk_tb);
        test_reset();
        test_echo_55();
        test_pending();
        test_back_to_back();
        test_collision();
        test_frame_err();
        test_key();
        test_baud_434();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
